// File: rtl/wb_serial_pkg.sv
// Shared types, command/response codes and response helpers for the
// byte-stream driven Wishbone master.
package wb_serial_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam logic [3:0] SEL_ALL = 4'hF;

    // Response bytes are left-aligned: the first byte to send sits in [39:32].
    function automatic logic [39:0] build_rsp(input logic ok, input logic we,
                                              input logic [31:0] rdata);
        logic [39:0] rsp;
        if (!ok) begin
            rsp = {RSP_NAK, 32'h0000_0000};
        end else if (we) begin
            rsp = {RSP_ACK, 32'h0000_0000};
        end else begin
            rsp = {RSP_ACK, rdata};
        end
        return rsp;
    endfunction

    function automatic logic [2:0] rsp_len(input logic ok, input logic we);
        logic [2:0] len;
        if (ok && !we) begin
            len = 3'd5;
        end else begin
            len = 3'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/wb_serial_if.sv
// Wishbone bus signals between the serial master and the interconnect slot.
interface wb_serial_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_serial_timeout.sv
// Reloadable down-counter: expired is high on the TIMEOUT-th enabled cycle
// after the last clear.
module wb_serial_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned WIDTH = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count_r;

    // Count down while enabled, saturating at zero; clear reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= LOAD_VAL;
        end else if (clear) begin
            count_r <= LOAD_VAL;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/wb_serial_master.sv
// Framed byte-stream to single-cycle 32-bit Wishbone initiator with byte
// responses (ACK + read data, or NAK on error/retry/timeout).
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int unsigned bus_timeout = 1024,
    parameter int unsigned rx_timeout  = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_busy,
    output logic        busy,
    wb_serial_if.master wb
);
    state_t      state_r, state_s;
    logic        we_flag_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] adr_sh_r;
    logic [23:0] dat_sh_r;
    logic [31:0] wb_adr_r, wb_dat_r;
    logic [3:0]  wb_sel_r;
    logic        wb_cyc_r, wb_stb_r, wb_we_r;
    logic [39:0] rsp_r;
    logic [2:0]  rsp_cnt_r;
    logic [7:0]  tx_data_r;
    logic        tx_stb_r, busy_r;

    logic in_frame_s, rx_exp_s, bus_exp_s, bus_done_s, bus_ok_s, tx_fire_s;

    assign in_frame_s = (state_r == ADDR) || (state_r == DATA);
    assign bus_done_s = wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i || bus_exp_s;
    assign bus_ok_s   = wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i;
    // The cycle after a strobe is a guard cycle so the transmitter can raise tx_busy.
    assign tx_fire_s  = (state_r == RESP) && !tx_busy && !tx_stb_r && (rsp_cnt_r != 3'd0);

    wb_serial_timeout #(.TIMEOUT(rx_timeout)) u_rx_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .clear   (rx_stb || !in_frame_s),
        .en      (in_frame_s && !rx_stb),
        .expired (rx_exp_s)
    );

    wb_serial_timeout #(.TIMEOUT(bus_timeout)) u_bus_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .clear   (state_r != BUS),
        .en      (state_r == BUS),
        .expired (bus_exp_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a received byte always wins over an rx timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_stb && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (rx_stb) begin
                    if (byte_cnt_r == 2'd3) begin
                        state_s = we_flag_r ? DATA : BUS;
                    end else begin
                        state_s = ADDR;
                    end
                end else if (rx_exp_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (rx_stb) begin
                    state_s = (byte_cnt_r == 2'd3) ? BUS : DATA;
                end else if (rx_exp_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            BUS: begin
                if (bus_done_s) begin
                    state_s = RESP;
                end else begin
                    state_s = BUS;
                end
            end
            RESP: begin
                if (rsp_cnt_r == 3'd0) begin
                    state_s = IDLE;
                end else if (tx_fire_s && (rsp_cnt_r == 3'd1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Frame capture, registered bus controls and response byte emission.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_flag_r  <= 1'b0;
            byte_cnt_r <= 2'd0;
            adr_sh_r   <= 32'h0000_0000;
            dat_sh_r   <= 24'h00_0000;
            wb_adr_r   <= 32'h0000_0000;
            wb_dat_r   <= 32'h0000_0000;
            wb_sel_r   <= 4'h0;
            wb_cyc_r   <= 1'b0;
            wb_stb_r   <= 1'b0;
            wb_we_r    <= 1'b0;
            rsp_r      <= 40'h00_0000_0000;
            rsp_cnt_r  <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_stb_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_stb_r <= tx_fire_s;
            busy_r   <= (state_s != IDLE);
            wb_cyc_r <= (state_s == BUS);
            wb_stb_r <= (state_s == BUS);
            wb_we_r  <= (state_s == BUS) && we_flag_r;
            wb_sel_r <= (state_s == BUS) ? SEL_ALL : 4'h0;
            case (state_r)
                IDLE: begin
                    byte_cnt_r <= 2'd0;
                    if (rx_stb && (rx_data == CMD_WR)) begin
                        we_flag_r <= 1'b1;
                    end else if (rx_stb && (rx_data == CMD_RD)) begin
                        we_flag_r <= 1'b0;
                    end
                end
                ADDR: begin
                    if (rx_stb) begin
                        adr_sh_r   <= {adr_sh_r[23:0], rx_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if ((byte_cnt_r == 2'd3) && !we_flag_r) begin
                            wb_adr_r <= {adr_sh_r[23:0], rx_data};
                        end
                    end
                end
                DATA: begin
                    if (rx_stb) begin
                        dat_sh_r   <= {dat_sh_r[15:0], rx_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            wb_adr_r <= adr_sh_r;
                            wb_dat_r <= {dat_sh_r, rx_data};
                        end
                    end
                end
                BUS: begin
                    if (bus_done_s) begin
                        rsp_r     <= build_rsp(bus_ok_s, we_flag_r, wb.wb_dat_i);
                        rsp_cnt_r <= rsp_len(bus_ok_s, we_flag_r);
                    end
                end
                RESP: begin
                    if (tx_fire_s) begin
                        tx_data_r <= rsp_r[39:32];
                        rsp_r     <= {rsp_r[31:0], 8'h00};
                        rsp_cnt_r <= rsp_cnt_r - 3'd1;
                    end
                end
                default: begin
                    byte_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign wb.wb_adr_o = wb_adr_r;
    assign wb.wb_dat_o = wb_dat_r;
    assign wb.wb_sel_o = wb_sel_r;
    assign wb.wb_we_o  = wb_we_r;
    assign wb.wb_cyc_o = wb_cyc_r;
    assign wb.wb_stb_o = wb_stb_r;
    assign tx_data     = tx_data_r;
    assign tx_stb      = tx_stb_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: frame-level model of expected bus
// cycles and response bytes, checked every cycle by one monitor process.
module tb_wb_serial_master;
    localparam int BUS_TO = 16;
    localparam int RX_TO  = 40;

    logic       clk, reset_n;
    logic [7:0] rx_data, tx_data;
    logic       rx_stb, tx_stb, tx_busy, busy;

    wb_serial_if wbif();

    wb_serial_master #(.bus_timeout(BUS_TO), .rx_timeout(RX_TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_data (rx_data),
        .rx_stb  (rx_stb),
        .tx_data (tx_data),
        .tx_stb  (tx_stb),
        .tx_busy (tx_busy),
        .busy    (busy),
        .wb      (wbif)
    );

    int checks = 0;
    int errors = 0;

    // Slave behaviour: 0 ack, 1 ack+err together, 2 rty, 3 silent.
    int          sl_mode = 0;
    int          sl_delay = 1;
    logic [31:0] sl_rdata = 32'h0;
    int          busy_len = 2;

    logic [31:0] exp_adr = 32'h0, exp_dat = 32'h0;
    logic        exp_we = 1'b0;
    logic [7:0]  tx_q[$];
    logic [7:0]  tx_log[$];

    int          n_cycles = 0, last_len = 0, cyc_len = 0, busy_cnt = 0;
    logic        in_cyc = 1'b0, prev_stb = 1'b0, prev_busy = 1'b0;
    logic [7:0]  last_tx = 8'h00;
    logic [31:0] last_adr = 32'h0, last_dat = 32'h0;
    logic        last_we = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic slave_idle();
        wbif.wb_ack_i = 1'b0;
        wbif.wb_err_i = 1'b0;
        wbif.wb_rty_i = 1'b0;
        wbif.wb_dat_i = 32'h0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor/compare process plus the slave and transmitter-busy models.
    initial begin
        logic [7:0] exp_b;
        slave_idle();
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_cyc = 1'b0; cyc_len = 0; busy_cnt = 0; tx_busy = 1'b0;
                prev_stb = 1'b0; prev_busy = 1'b0; last_tx = 8'h00;
                slave_idle();
            end else begin
                if (tx_stb) begin
                    chk("tx_guard", 64'(prev_stb), 64'(0));
                    chk("tx_busy_rule", 64'(prev_busy), 64'(0));
                    tx_log.push_back(tx_data);
                    if (tx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected actual %0h required none", tx_data);
                    end else begin
                        exp_b = tx_q.pop_front();
                        chk("tx_data", 64'(tx_data), 64'(exp_b));
                    end
                    last_tx  = tx_data;
                    busy_cnt = busy_len;
                end else begin
                    chk("tx_hold", 64'(tx_data), 64'(last_tx));
                end
                prev_stb = tx_stb;
                if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
                prev_busy = tx_busy;

                if (wbif.wb_cyc_o) begin
                    if (!in_cyc) begin
                        in_cyc = 1'b1;
                        cyc_len = 0;
                    end
                    cyc_len++;
                    chk("wb_adr", 64'(wbif.wb_adr_o), 64'(exp_adr));
                    chk("wb_we", 64'(wbif.wb_we_o), 64'(exp_we));
                    chk("wb_sel", 64'(wbif.wb_sel_o), 64'(4'hF));
                    chk("wb_stb", 64'(wbif.wb_stb_o), 64'(1));
                    if (exp_we) chk("wb_dat", 64'(wbif.wb_dat_o), 64'(exp_dat));
                    last_adr = wbif.wb_adr_o;
                    last_dat = wbif.wb_dat_o;
                    last_we  = wbif.wb_we_o;
                    if (cyc_len == sl_delay) begin
                        case (sl_mode)
                            0: begin wbif.wb_ack_i = 1'b1; wbif.wb_dat_i = sl_rdata; end
                            1: begin wbif.wb_ack_i = 1'b1; wbif.wb_err_i = 1'b1; end
                            2: wbif.wb_rty_i = 1'b1;
                            default: ;
                        endcase
                    end
                end else begin
                    chk("idle_ctrl", 64'({wbif.wb_stb_o, wbif.wb_we_o, wbif.wb_sel_o}), 64'(0));
                    if (in_cyc) begin
                        n_cycles++;
                        last_len = cyc_len;
                        in_cyc = 1'b0;
                    end
                    slave_idle();
                end
            end
        end
    end

    // Expected response bytes from the outcome of a bus cycle.
    task automatic model_push(input logic we, input int mode, input logic [31:0] rd);
        if (mode == 0) begin
            tx_q.push_back(8'h06);
            if (!we) for (int i = 3; i >= 0; i--) tx_q.push_back(rd[8*i +: 8]);
        end else begin
            tx_q.push_back(8'h15);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!busy && (tx_q.size() == 0) && !tx_busy && !wbif.wb_cyc_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        logic [7:0] fr[9];
        int n;
        fr[0] = we ? 8'h57 : 8'h52;
        for (int i = 0; i < 4; i++) fr[1+i] = adr[31-8*i -: 8];
        for (int i = 0; i < 4; i++) fr[5+i] = dat[31-8*i -: 8];
        n = we ? 9 : 5;
        for (int i = 0; i < n - 1; i++) send_byte(fr[i], 2);
        send_byte(fr[n-1], 0);
        #1;
        chk("cyc_start", 64'(wbif.wb_cyc_o), 64'(1));
    endtask

    task automatic run_txn(input string name, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input int mode, input int dly,
                           input logic [31:0] rd);
        int n0, exp_len;
        sl_mode = mode; sl_delay = dly; sl_rdata = rd;
        exp_adr = adr; exp_dat = dat; exp_we = we;
        exp_len = (mode == 3) ? BUS_TO : dly;
        model_push(we, mode, rd);
        n0 = n_cycles;
        send_frame(we, adr, dat);
        wait_idle({name, "_done"});
        chk({name, "_bus_count"}, 64'(n_cycles), 64'(n0 + 1));
        chk({name, "_cyc_len"}, 64'(last_len), 64'(exp_len));
    endtask

    initial begin
        int n0;
        reset_n = 1'b1; rx_stb = 1'b0; rx_data = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_outputs", 64'({tx_data, tx_stb, busy, wbif.wb_cyc_o, wbif.wb_stb_o,
                                wbif.wb_we_o, wbif.wb_sel_o}), 64'(0));
        chk("rst_adr", 64'(wbif.wb_adr_o), 64'(0));
        chk("rst_dat", 64'(wbif.wb_dat_o), 64'(0));
        #20 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write with a 3-cycle ack.
        run_txn("write", 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 3, 32'h0);
        chk("pin_wr_adr", 64'(last_adr), 64'h4000_0010);
        chk("pin_wr_dat", 64'(last_dat), 64'hDEAD_BEEF);
        chk("pin_wr_we", 64'(last_we), 64'(1));
        chk("pin_wr_len", 64'(last_len), 64'(3));
        chk("pin_wr_tx", 64'(tx_log[tx_log.size()-1]), 64'h06);

        // Read, zero-wait ack, slow transmitter.
        busy_len = 10;
        tx_log.delete();
        run_txn("read", 1'b0, 32'h7000_0000, 32'h0, 0, 1, 32'h1234_5678);
        chk("pin_rd_count", 64'(tx_log.size()), 64'(5));
        if (tx_log.size() == 5)
            chk("pin_rd_bytes", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}),
                64'h06_1234_5678);
        chk("pin_rd_we", 64'(last_we), 64'(0));
        busy_len = 2;

        // Silent slave: bus timeout.
        tx_log.delete();
        run_txn("timeout", 1'b0, 32'h5000_0000, 32'h0, 3, 1, 32'h0);
        chk("pin_to_len", 64'(last_len), 64'(16));
        chk("pin_to_tx", 64'(tx_log[0]), 64'h15);

        // ack+err together on a write, then rty alone on a read.
        run_txn("ack_err", 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1, 1, 32'h0);
        run_txn("rty", 1'b0, 32'h0000_0200, 32'h0, 2, 2, 32'hFFFF_FFFF);

        // Garbage then partial frame abandoned by the rx idle timer.
        n0 = n_cycles;
        send_byte(8'hAA, 2);
        send_byte(8'h00, 2);
        #1 chk("garbage_idle", 64'(busy), 64'(0));
        send_byte(8'h57, 2);
        send_byte(8'h40, 0);
        repeat (RX_TO - 1) @(negedge clk);
        #1 chk("rx_to_before", 64'(busy), 64'(1));
        @(negedge clk);
        #1 chk("rx_to_after", 64'(busy), 64'(0));
        repeat (5) @(negedge clk);
        chk("rx_to_no_bus", 64'(n_cycles), 64'(n0));
        run_txn("after_garbage", 1'b1, 32'h1000_0004, 32'h0102_0304, 0, 2, 32'h0);

        // Asynchronous reset while the bus cycle is open.
        sl_mode = 3; exp_adr = 32'h2000_0000; exp_we = 1'b0;
        send_frame(1'b0, 32'h2000_0000, 32'h0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cyc", 64'({wbif.wb_cyc_o, wbif.wb_stb_o, tx_stb}), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        tx_q.delete();
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn("after_reset", 1'b1, 32'h3000_0008, 32'h5555_AAAA, 0, 1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
Name: wb_serial_master

Overview:
- Wishbone bus initiator driven by a byte stream. Intended to sit between a UART byte receiver/transmitter and master slot m2 of the system interconnect.
- Decodes framed read/write commands, runs single 32-bit Wishbone cycles and returns results as bytes.
- Gives a host PC peek/poke access to BRAM, SRAM and peripherals alongside the LM32 CPU.

Parameters:
- bus_timeout, 1024, clock cycles to wait for ack/err/rty before aborting a bus cycle (>=2).
- rx_timeout, 500000, idle clock cycles inside a partial frame before the frame is discarded (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_stb  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_stb  out  1  one-cycle strobe, tx_data valid.
- tx_busy  in  1  transmitter busy; high means tx_stb must not be issued.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte select; always 4'hF during a cycle.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_rty_i  in  1  slave retry; treated as error.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: every output is 0 and state is IDLE, including tx_data, wb_adr_o, wb_dat_o, wb_sel_o and all strobes. Reset acts asynchronously at any point, including mid-bus-cycle or mid-response; cyc/stb drop immediately.
- Frame formats:
  - Write: 0x57, A3 A2 A1 A0, D3 D2 D1 D0. MSB first.
  - Read: 0x52, A3 A2 A1 A0.
- IDLE:
  - rx_stb with 0x57 -> ADDR, we flag set.
  - rx_stb with 0x52 -> ADDR, we flag clear.
  - Any other byte is ignored and state stays IDLE.
- ADDR: shift in 4 bytes, byte count 0..3. After the 4th byte, go to DATA if we flag is set, else BUS.
- DATA: shift in 4 bytes, then go to BUS.
- rx idle timer:
  - Active in ADDR and DATA; cleared on each rx_stb.
  - Reaching rx_timeout returns to IDLE with no bus cycle and no response.
- rx_stb in BUS or RESP: byte dropped; state unaffected.
- BUS:
  - wb_cyc_o, wb_stb_o, wb_we_o and wb_sel_o=4'hF are asserted on the clock edge after the last frame byte.
  - They are held stable until one of: wb_ack_i, wb_err_i, wb_rty_i, or the bus timer reaching bus_timeout.
  - On that cycle cyc/stb/we drop at the next edge; no back-to-back bus cycles.
  - Read ack: capture wb_dat_i on the ack cycle.
  - ack and err in the same cycle: err takes priority.
- Response status:
  - Write ack -> 0x06.
  - Read ack -> 0x06 followed by D3 D2 D1 D0 (5 bytes).
  - err, rty or timeout -> single byte 0x15 for both reads and writes.
- RESP:
  - Emit queued bytes in order.
  - tx_stb is pulsed for one cycle with tx_data valid only when tx_busy=0 and tx_stb was not asserted in the previous cycle (one guard cycle lets the transmitter raise tx_busy).
  - tx_data holds its value after the strobe.
  - After the last byte, go to IDLE.
- wb_adr_o and wb_dat_o hold their last values between cycles.

Decomposition:
- Package wb_serial_pkg:
  - State enum: IDLE, ADDR, DATA, BUS, RESP.
  - Constants: CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15.
- Timer width via $clog2 of each timeout parameter.
- One natural sub-module, wb_serial_timeout: loadable down-counter with clear, enable and expired output. Instantiated twice (rx idle, bus).

Test Plan:
- Write: bytes 57 40 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one bus cycle with adr=0x40000010, dat_o=0xDEADBEEF, we=1, sel=F, cyc high exactly 3 cycles after the byte-9 edge; tx emits 0x06.
- Read: bytes 52 70 00 00 00, slave returns 0x12345678 with 0-wait ack -> we=0; tx emits 06 12 34 56 78 in order. With tx_busy held high 10 cycles after each strobe, there are no lost or duplicated bytes.
- Bus timeout (bus_timeout=16): read of 0x50000000, no ack -> cyc drops after exactly 16 cycles; tx emits 0x15; busy returns low.
- Error priority: ack and err asserted in the same cycle on a write -> response 0x15. rty alone -> 0x15.
- Resync and garbage: bytes AA 00 57 40 then silence > rx_timeout -> no bus cycle, no tx, state IDLE. A following valid write frame completes normally.
- Reset mid-cycle: reset_n pulled low while cyc high -> cyc/stb/tx_stb go 0 asynchronously. After release, state is IDLE and the next frame works.
